serial_word_arbiter: RTL and testbench

- Shares one serial-to-parallel word assembler between N serial requesters.
- Grants one requester at a time for exactly one `width`-bit word, using round-robin priority.
- Assembles that requester's bits LSB-first and presents the word with its source index on a valid/ready parallel output.
- Sits between several single-bit serial links and one downstream parallel consumer.

---
 rtl/serial_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/serial_word_arbiter.sv | 146 ++++++++++++++
 tb/tb_serial_word_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_arb_pkg
// Brief    : Shared types and helpers for the serial word arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package serial_arb_pkg;

  // FSM encoding for the word arbiter
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  // Bit counter must be able to hold the value width itself
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage : serial_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker. Returns the first requester
//            at or after the priority pointer, wrapping round.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int N_SRC = 4,
  localparam int SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [N_SRC-1:0] winner,
  output logic [SRC_W-1:0] winner_idx,
  output logic             any_req
);

  localparam logic [SRC_W:0] c_n_src = (SRC_W+1)'(N_SRC);

  logic [SRC_W:0]   w_sum;
  logic [SRC_W-1:0] w_idx;
  logic             w_found;

  // Scan requesters starting at the pointer; the first hit wins
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    w_found    = 1'b0;
    w_sum      = '0;
    w_idx      = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_sum = {1'b0, ptr} + (SRC_W+1)'(i);
      if (w_sum >= c_n_src) begin
        w_sum = w_sum - c_n_src;
      end
      w_idx = w_sum[SRC_W-1:0];
      if (!w_found && req[w_idx]) begin
        w_found       = 1'b1;
        winner_idx    = w_idx;
        winner[w_idx] = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/serial_word_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_arbiter
// Brief    : Round-robin share of one serial-to-parallel word assembler
//            between N single-bit requesters. Bits arrive LSB-first; the
//            finished word is held on a valid/ready output with its source.
// Revision : 1.0 - initial release
// ============================================================================
module serial_word_arbiter
  import serial_arb_pkg::*;
#(
  parameter  int N_SRC = 4,
  parameter  int WIDTH = 8,
  localparam int SRC_W = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] serial_valid,
  input  logic [N_SRC-1:0] serial_data,
  output logic [N_SRC-1:0] grant,
  output logic             parallel_valid,
  output logic [WIDTH-1:0] parallel_data,
  output logic [SRC_W-1:0] parallel_src,
  input  logic             parallel_ready
);

  localparam int               CNT_W      = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);
  localparam logic [SRC_W-1:0] c_last_src = SRC_W'(N_SRC - 1);

  state_t           r_state;
  logic [SRC_W-1:0] r_owner;
  logic [SRC_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [N_SRC-1:0] r_grant;
  logic             r_pvalid;
  logic [WIDTH-1:0] r_pdata;
  logic [SRC_W-1:0] r_psrc;

  logic [N_SRC-1:0] w_win_onehot;
  logic [SRC_W-1:0] w_win_idx;
  logic             w_any_req;
  logic             w_own_req;
  logic             w_own_valid;
  logic             w_own_data;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_shift_next;
  logic [SRC_W-1:0] w_ptr_next;

  rr_arbiter #(
    .N_SRC (N_SRC)
  ) u_rr_arbiter (
    .req        (req),
    .ptr        (r_ptr),
    .winner     (w_win_onehot),
    .winner_idx (w_win_idx),
    .any_req    (w_any_req)
  );

  // Only the owner's lane is looked at; other lanes never reach the shifter
  assign w_own_req   = req[r_owner];
  assign w_own_valid = serial_valid[r_owner];
  assign w_own_data  = serial_data[r_owner];

  assign w_accept = (r_state == ST_COLLECT) && w_own_valid;
  assign w_last   = w_accept && (r_cnt == c_last_bit);

  // The shifter is cleared at grant time, so each bit can simply be OR-ed in
  assign w_shift_next = r_shift | ({{(WIDTH-1){1'b0}}, w_own_data} << r_cnt);

  // Priority moves to the requester just after the one served
  assign w_ptr_next = (r_owner == c_last_src) ? '0 : r_owner + SRC_W'(1);

  // Word FSM: grant, collect LSB-first, then hold until the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_grant  <= '0;
      r_pvalid <= 1'b0;
      r_pdata  <= '0;
      r_psrc   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_win_idx;
            r_grant <= w_win_onehot;
            r_cnt   <= '0;
            r_shift <= '0;
            r_state <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          // A final bit completes the word even if req drops in that cycle
          if (w_last) begin
            r_pdata  <= w_shift_next;
            r_psrc   <= r_owner;
            r_pvalid <= 1'b1;
            r_grant  <= '0;
            r_cnt    <= '0;
            r_state  <= ST_HOLD;
          end else if (!w_own_req) begin
            r_grant <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_ptr   <= w_ptr_next;
            r_state <= ST_IDLE;
          end else if (w_accept) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end

        ST_HOLD: begin
          if (parallel_ready) begin
            r_pvalid <= 1'b0;
            r_ptr    <= w_ptr_next;
            r_state  <= ST_IDLE;
          end
        end

        default: begin
          r_grant  <= '0;
          r_pvalid <= 1'b0;
          r_cnt    <= '0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant          = r_grant;
  assign parallel_valid = r_pvalid;
  assign parallel_data  = r_pdata;
  assign parallel_src   = r_psrc;

endmodule : serial_word_arbiter
`default_nettype wire

// File: tb/tb_serial_word_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_word_arbiter
// Brief    : Directed self-checking bench for serial_word_arbiter
//            (4 requesters, 8-bit words).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_word_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] serial_valid;
  logic [3:0] serial_data;
  logic [3:0] grant;
  logic       parallel_valid;
  logic [7:0] parallel_data;
  logic [1:0] parallel_src;
  logic       parallel_ready;

  int n_vec = 0;
  int n_err = 0;

  serial_word_arbiter #(
    .N_SRC (4),
    .WIDTH (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .serial_valid   (serial_valid),
    .serial_data    (serial_data),
    .grant          (grant),
    .parallel_valid (parallel_valid),
    .parallel_data  (parallel_data),
    .parallel_src   (parallel_src),
    .parallel_ready (parallel_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    req            = '0;
    serial_valid   = '0;
    serial_data    = '0;
    parallel_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for any grant, then require it to be the given requester
  task automatic wait_grant(input int src);
    int i;
    i = 0;
    while (grant == 4'b0000 && i < 20) begin
      tick();
      i++;
    end
    check_val("grant", {28'd0, grant}, 32'(1) << src);
  endtask

  // Drive nbits LSB-first on lane src, optionally with an idle cycle between bits
  task automatic send_bits(input int src, input logic [7:0] word, input int nbits, input bit gap);
    for (int k = 0; k < nbits; k++) begin
      serial_valid[src] = 1'b1;
      serial_data[src]  = word[k];
      tick();
      if (gap && k < nbits - 1) begin
        serial_valid[src] = 1'b0;
        serial_data[src]  = ~word[k];
        tick();
      end
    end
    serial_valid[src] = 1'b0;
    serial_data[src]  = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [7:0] data, input logic [1:0] src);
    check_val({tag, "_valid"}, {31'd0, parallel_valid}, 32'd1);
    check_val({tag, "_data"},  {24'd0, parallel_data},  {24'd0, data});
    check_val({tag, "_src"},   {30'd0, parallel_src},   {30'd0, src});
    check_val({tag, "_grant"}, {28'd0, grant},          32'd0);
  endtask

  initial begin
    logic [1:0] rr_seq [5];
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // ---- reset state
    do_reset();
    check_val("rst_grant", {28'd0, grant}, 32'd0);
    check_val("rst_valid", {31'd0, parallel_valid}, 32'd0);
    check_val("rst_data",  {24'd0, parallel_data}, 32'd0);
    check_val("rst_src",   {30'd0, parallel_src}, 32'd0);

    // ---- single requester, 1-cycle grant latency, word 8'h4D
    req = 4'b0100;
    tick();
    check_val("single_grant", {28'd0, grant}, 32'h4);
    send_bits(2, 8'h4D, 8, 1'b0);
    check_word("single", 8'h4D, 2'd2);
    req = 4'b0000;
    tick();
    check_val("single_release", {31'd0, parallel_valid}, 32'd0);

    // ---- round robin, all requesting
    do_reset();
    req = 4'b1111;
    for (int w = 0; w < 5; w++) begin
      wait_grant(int'(rr_seq[w]));
      send_bits(int'(rr_seq[w]), 8'hA5, 8, 1'b0);
      check_word("rr", 8'hA5, rr_seq[w]);
      if (w == 4) req = 4'b0000;
      tick();
    end

    // ---- backpressure: held stable with no grant for 5 cycles
    do_reset();
    parallel_ready = 1'b0;
    req = 4'b0010;
    wait_grant(1);
    send_bits(1, 8'h5A, 8, 1'b0);
    for (int c = 0; c < 5; c++) begin
      check_word("bp", 8'h5A, 2'd1);
      tick();
    end
    parallel_ready = 1'b1;
    req = 4'b0000;
    tick();
    check_val("bp_release", {31'd0, parallel_valid}, 32'd0);

    // ---- abort after 3 bits, then a clean word from the same requester
    do_reset();
    req = 4'b0010;
    wait_grant(1);
    send_bits(1, 8'hFF, 3, 1'b0);
    req = 4'b0000;
    tick();
    check_val("abort_grant", {28'd0, grant}, 32'd0);
    tick();
    check_val("abort_valid", {31'd0, parallel_valid}, 32'd0);
    req = 4'b0010;
    wait_grant(1);
    send_bits(1, 8'h3C, 8, 1'b0);
    check_word("after_abort", 8'h3C, 2'd1);
    req = 4'b0000;
    tick();

    // ---- gaps on owner 0 while requester 3 drives constant foreign traffic
    do_reset();
    req = 4'b1001;
    serial_valid[3] = 1'b1;
    serial_data[3]  = 1'b1;
    wait_grant(0);
    send_bits(0, 8'h96, 8, 1'b1);
    check_word("gap", 8'h96, 2'd0);
    req = 4'b0000;
    serial_valid = '0;
    serial_data  = '0;
    tick();

    // ---- async reset mid-collect, after a completed word left data behind
    do_reset();
    req = 4'b0100;
    wait_grant(2);
    send_bits(2, 8'hE7, 8, 1'b0);
    check_word("pre_rst", 8'hE7, 2'd2);
    req = 4'b0001;
    wait_grant(0);
    send_bits(0, 8'hFF, 4, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_val("arst_grant", {28'd0, grant}, 32'd0);
    check_val("arst_valid", {31'd0, parallel_valid}, 32'd0);
    check_val("arst_data",  {24'd0, parallel_data}, 32'd0);
    check_val("arst_src",   {30'd0, parallel_src}, 32'd0);
    tick();
    rst = 1'b0;
    wait_grant(0);
    send_bits(0, 8'h81, 8, 1'b0);
    check_word("post_rst", 8'h81, 2'd0);
    req = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the bench can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_word_arbiter
`default_nettype wire
